// File: rtl/pipeline_reg_pkg.sv
// Shared pipeline types: BTB entry layout and branch-predictor sizing constants.
package pipeline_reg_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned BP_ENTRIES = 16;
    localparam int unsigned BP_IDX_W   = 4;
    localparam int unsigned BP_TAG_W   = 26;
    localparam int unsigned BP_CTR_W   = 2;

    typedef struct packed {
        logic                valid;
        logic [BP_TAG_W-1:0] tag;
        logic [XLEN-1:0]     target;
        logic [BP_CTR_W-1:0] ctr;
    } bp_entry_t;

    // Direct-mapped set selection: word-aligned PC bits above the byte offset.
    function automatic logic [BP_IDX_W-1:0] bp_index(input logic [XLEN-1:0] pc);
        return pc[5:2];
    endfunction

    function automatic logic [BP_TAG_W-1:0] bp_tag(input logic [XLEN-1:0] pc);
        return pc[31:6];
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-side lookup and MEM-side resolution bundle between the pipeline and the predictor.
interface branch_predictor_if;
    import pipeline_reg_pkg::*;

    logic [XLEN-1:0]     fetch_pc;
    logic                pred_taken;
    logic [XLEN-1:0]     pred_target;
    logic [BP_IDX_W-1:0] pred_index;

    logic                upd_en;
    logic [BP_IDX_W-1:0] upd_index;
    logic [XLEN-1:0]     upd_pc;
    logic                upd_taken;
    logic [XLEN-1:0]     upd_target;
    logic                upd_predict;
    logic                mispredict;
    logic [XLEN-1:0]     recover_pc;

    modport master (
        output fetch_pc, upd_en, upd_index, upd_pc, upd_taken, upd_target, upd_predict,
        input  pred_taken, pred_target, pred_index, mispredict, recover_pc
    );

    modport slave (
        input  fetch_pc, upd_en, upd_index, upd_pc, upd_taken, upd_target, upd_predict,
        output pred_taken, pred_target, pred_index, mispredict, recover_pc
    );

endinterface

// File: rtl/sat_counter2.sv
// Two-bit saturating up/down counter next-value logic.
module sat_counter2
    import pipeline_reg_pkg::*;
(
    input  logic                inc,
    input  logic                dec,
    input  logic [BP_CTR_W-1:0] cur,
    output logic [BP_CTR_W-1:0] next
);

    always_comb begin
        next = cur;
        if (inc && !dec && (cur != 2'b11)) begin
            next = cur + BP_CTR_W'(1);
        end else if (dec && !inc && (cur != 2'b00)) begin
            next = cur - BP_CTR_W'(1);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// 16-entry direct-mapped BTB with 2-bit counters and same-cycle mispredict detection.
// Defining BP_STATS_EN adds branch / mispredict event counters as extra outputs.
module branch_predictor
    import pipeline_reg_pkg::*;
#(
    parameter logic [1:0] INIT_CTR = 2'b01
) (
    input  logic              CLK,
    input  logic              nRST,
    branch_predictor_if.slave bp
`ifdef BP_STATS_EN
    ,
    output logic [31:0]       stat_branches,
    output logic [31:0]       stat_mispredicts
`endif
);

    localparam bp_entry_t RESET_ENTRY = '{valid: 1'b0, tag: '0, target: '0, ctr: INIT_CTR};

    bp_entry_t           table_q [BP_ENTRIES];
    bp_entry_t           fetch_entry;
    bp_entry_t           upd_entry;
    bp_entry_t           next_entry;
    logic                fetch_hit;
    logic                upd_hit;
    logic                write_en;
    logic [BP_CTR_W-1:0] ctr_next;

    // Lookup reads the registered table only, so an in-flight update is not visible yet.
    assign fetch_entry = table_q[bp_index(bp.fetch_pc)];
    assign fetch_hit   = fetch_entry.valid && (fetch_entry.tag == bp_tag(bp.fetch_pc));

    assign bp.pred_index  = bp_index(bp.fetch_pc);
    assign bp.pred_taken  = fetch_hit && fetch_entry.ctr[1];
    assign bp.pred_target = fetch_hit ? fetch_entry.target : (bp.fetch_pc + XLEN'(4));

    assign bp.mispredict = bp.upd_en && (bp.upd_taken != bp.upd_predict);
    assign bp.recover_pc = bp.upd_taken ? bp.upd_target : (bp.upd_pc + XLEN'(4));

    assign upd_entry = table_q[bp.upd_index];
    assign upd_hit   = upd_entry.valid && (upd_entry.tag == bp_tag(bp.upd_pc));

    sat_counter2 u_ctr (
        .inc  (bp.upd_taken),
        .dec  (!bp.upd_taken),
        .cur  (upd_entry.ctr),
        .next (ctr_next)
    );

    // Train on a hit; allocate only for taken misses so not-taken aliases never evict.
    always_comb begin
        next_entry = upd_entry;
        write_en   = 1'b0;
        if (bp.upd_en) begin
            if (upd_hit) begin
                write_en       = 1'b1;
                next_entry.ctr = ctr_next;
                if (bp.upd_taken) begin
                    next_entry.target = bp.upd_target;
                end
            end else if (bp.upd_taken) begin
                write_en          = 1'b1;
                next_entry.valid  = 1'b1;
                next_entry.tag    = bp_tag(bp.upd_pc);
                next_entry.target = bp.upd_target;
                next_entry.ctr    = 2'b10;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int unsigned i = 0; i < BP_ENTRIES; i++) begin
                table_q[i] <= RESET_ENTRY;
            end
        end else if (write_en) begin
            table_q[bp.upd_index] <= next_entry;
        end
    end

`ifdef BP_STATS_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (bp.upd_en) begin
                stat_branches <= stat_branches + 32'd1;
            end
            if (bp.mispredict) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (optionally built with BP_STATS_EN).
module tb_branch_predictor;
    import pipeline_reg_pkg::*;

    logic CLK = 1'b0;
    logic nRST;
    int   checks   = 0;
    int   failures = 0;
    int   exp_branches = 0;
    int   exp_mispred  = 0;

    branch_predictor_if bp ();

`ifdef BP_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    branch_predictor #(.INIT_CTR(2'b01)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bp   (bp)
`ifdef BP_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic look(input logic [31:0] pc, input logic exp_taken, input logic [31:0] exp_target);
        @(negedge CLK);
        bp.fetch_pc = pc;
        #1;
        check("pred_taken", 32'(bp.pred_taken), 32'(exp_taken));
        check("pred_target", bp.pred_target, exp_target);
    endtask

    task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] target,
                       input logic predict, input logic exp_mis, input logic [31:0] exp_rec);
        logic [31:0] pcv;
        pcv = pc;
        @(negedge CLK);
        bp.upd_en      = 1'b1;
        bp.upd_index   = pcv[5:2];
        bp.upd_pc      = pc;
        bp.upd_taken   = taken;
        bp.upd_target  = target;
        bp.upd_predict = predict;
        #1;
        check("mispredict", 32'(bp.mispredict), 32'(exp_mis));
        check("recover_pc", bp.recover_pc, exp_rec);
        exp_branches++;
        if (exp_mis) exp_mispred++;
        @(posedge CLK);
        #1;
        bp.upd_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with an update pending: outputs follow the combinational rules, update is dropped.
        nRST           = 1'b0;
        bp.fetch_pc    = 32'h0000_0040;
        bp.upd_en      = 1'b1;
        bp.upd_index   = 4'd0;
        bp.upd_pc      = 32'h0000_0040;
        bp.upd_taken   = 1'b1;
        bp.upd_target  = 32'h0000_0100;
        bp.upd_predict = 1'b0;
        repeat (2) @(negedge CLK);
        #1;
        check("rst_pred_taken", 32'(bp.pred_taken), 32'd0);
        check("rst_pred_target", bp.pred_target, 32'h0000_0044);
        check("rst_pred_index", 32'(bp.pred_index), 32'd0);
        check("rst_mispredict", 32'(bp.mispredict), 32'd1);
        check("rst_recover_pc", bp.recover_pc, 32'h0000_0100);
`ifdef BP_STATS_EN
        check("rst_stat_branches", stat_branches, 32'd0);
        check("rst_stat_mispredicts", stat_mispredicts, 32'd0);
`endif
        @(negedge CLK);
        bp.upd_en = 1'b0;
        nRST      = 1'b1;
        look(32'h0000_0040, 1'b0, 32'h0000_0044);

        // Taken allocation with a same-cycle lookup of the same entry (must see old contents).
        @(negedge CLK);
        bp.fetch_pc    = 32'h0000_0040;
        bp.upd_en      = 1'b1;
        bp.upd_index   = 4'd0;
        bp.upd_pc      = 32'h0000_0040;
        bp.upd_taken   = 1'b1;
        bp.upd_target  = 32'h0000_0100;
        bp.upd_predict = 1'b0;
        #1;
        check("alloc_mispredict", 32'(bp.mispredict), 32'd1);
        check("alloc_recover_pc", bp.recover_pc, 32'h0000_0100);
        check("bypass_pred_taken", 32'(bp.pred_taken), 32'd0);
        check("bypass_pred_target", bp.pred_target, 32'h0000_0044);
        exp_branches++;
        exp_mispred++;
        @(posedge CLK);
        #1;
        bp.upd_en = 1'b0;
        check("alloc_pred_taken", 32'(bp.pred_taken), 32'd1);
        check("alloc_pred_target", bp.pred_target, 32'h0000_0100);

        // Alias at the same index with a different tag: no hit, not-taken update leaves entry.
        look(32'h0000_0080, 1'b0, 32'h0000_0084);
        upd(32'h0000_0080, 1'b0, 32'h0000_0999, 1'b0, 1'b0, 32'h0000_0084);
        look(32'h0000_0040, 1'b1, 32'h0000_0100);

        // Counter walk down 2->1->0, then saturation at 0.
        upd(32'h0000_0040, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0044);
        look(32'h0000_0040, 1'b0, 32'h0000_0100);
        upd(32'h0000_0040, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0000_0044);
        look(32'h0000_0040, 1'b0, 32'h0000_0100);
        upd(32'h0000_0040, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0000_0044);
        upd(32'h0000_0040, 1'b1, 32'h0000_0100, 1'b0, 1'b1, 32'h0000_0100);
        look(32'h0000_0040, 1'b0, 32'h0000_0100);

        // Counter walk up 1->2->3->3->3 with a new target, then back down 3->2->1.
        for (int i = 0; i < 4; i++) begin
            upd(32'h0000_0040, 1'b1, 32'h0000_0200, 1'b0, 1'b1, 32'h0000_0200);
        end
        look(32'h0000_0040, 1'b1, 32'h0000_0200);
        upd(32'h0000_0040, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0044);
        look(32'h0000_0040, 1'b1, 32'h0000_0200);
        upd(32'h0000_0040, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0044);
        look(32'h0000_0040, 1'b0, 32'h0000_0200);

        // PC+4 wraps modulo 2^32 on both lookup and recovery paths.
        upd(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0000_0000);
        look(32'hFFFF_FFFC, 1'b0, 32'h0000_0000);

        // Allocation at a different index; index output and isolation from index 0.
        look(32'h1234_5678, 1'b0, 32'h1234_567C);
        check("pred_index_e", 32'(bp.pred_index), 32'h0000_000E);
        upd(32'h1234_5678, 1'b1, 32'h0000_ABC0, 1'b1, 1'b0, 32'h0000_ABC0);
        look(32'h1234_5678, 1'b1, 32'h0000_ABC0);
        look(32'h0000_0040, 1'b0, 32'h0000_0200);
        repeat (3) @(posedge CLK);
        look(32'h1234_5678, 1'b1, 32'h0000_ABC0);

`ifdef BP_STATS_EN
        check("stat_branches", stat_branches, 32'(exp_branches));
        check("stat_mispredicts", stat_mispredicts, 32'(exp_mispred));
`endif

        // Asynchronous reset mid-cycle clears the table.
        @(posedge CLK);
        #2;
        nRST = 1'b0;
        #1;
        check("async_rst_taken", 32'(bp.pred_taken), 32'd0);
        check("async_rst_target", bp.pred_target, 32'h1234_567C);
`ifdef BP_STATS_EN
        check("async_rst_stat", stat_branches, 32'd0);
`endif
        @(negedge CLK);
        nRST = 1'b1;
        look(32'h0000_0040, 1'b0, 32'h0000_0044);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL expose parameter INIT_CTR, default 2'b01, meaning the 2-bit counter value every entry takes at reset (weakly not-taken).
REQ-002 SHALL expose port CLK  in  1  rising-edge clock.
REQ-003 SHALL expose port nRST  in  1  asynchronous, active-low reset.
REQ-004 SHALL expose port fetch_pc  in  32  PC of the instruction being fetched this cycle.
REQ-005 SHALL expose port pred_taken  out  1  predict taken; goes to ifid/idex predict.
REQ-006 SHALL expose port pred_target  out  32  predicted target; goes to br_target.
REQ-007 SHALL expose port pred_index  out  4  fetch_pc[5:2]; carried down the pipe as index.
REQ-008 SHALL expose port upd_en  in  1  resolved branch in MEM stage, qualified by not-stalled.
REQ-009 SHALL expose port upd_index  in  4  exmem index.
REQ-010 SHALL expose port upd_pc  in  32  PC of the resolved branch.
REQ-011 SHALL expose port upd_taken  in  1  actual outcome.
REQ-012 SHALL expose port upd_target  in  32  computed branch target.
REQ-013 SHALL expose port upd_predict  in  1  prediction made at fetch (exmem predict).
REQ-014 SHALL expose port mispredict  out  1  flush request to the hazard unit.
REQ-015 SHALL expose port recover_pc  out  32  correct next PC on mispredict.

Function
REQ-016 Table SHALL hold 16 direct-mapped entries: valid, tag = pc[31:6], target[31:0], ctr[1:0].
REQ-017 Lookup SHALL be combinational: hit = valid & tag match at fetch_pc[5:2]; pred_taken = hit & ctr[1]; pred_target = entry target when hit, else fetch_pc+4.
REQ-018 mispredict SHALL be upd_en & (upd_taken != upd_predict), combinational, same cycle.
REQ-019 recover_pc SHALL be upd_target when upd_taken, else upd_pc+4 (32-bit, wraps modulo 2^32).
REQ-020 On upd_en with a hit at upd_index, ctr SHALL saturate-increment when taken and saturate-decrement when not taken (3 stays 3, 0 stays 0); target SHALL be rewritten with upd_target when taken.
REQ-021 On upd_en & upd_taken with a miss (invalid or tag mismatch), the entry SHALL be allocated: valid=1, tag, target, ctr=2'b10.
REQ-022 On upd_en & !upd_taken with a miss, the table SHALL be unchanged.
REQ-023 Table updates SHALL commit on the CLK edge; a same-cycle lookup of the entry being updated SHALL see the old contents (no bypass).
REQ-024 With upd_en low, the table SHALL hold state.

Reset
REQ-025 nRST low SHALL asynchronously clear every valid bit, set every ctr to INIT_CTR, and zero tags and targets.
REQ-026 During reset, pred_taken SHALL be 0 and pred_target SHALL be fetch_pc+4; mispredict SHALL follow REQ-018.
REQ-027 Reset asserted mid-update SHALL discard the update.

Configuration
REQ-028 With BP_STATS_EN defined, the module SHALL add outputs stat_branches and stat_mispredicts (32 bits each), reset to 0. On each upd_en, stat_branches SHALL increment by 1. On each mispredict, stat_mispredicts SHALL increment by 1. Both SHALL wrap at 2^32.
REQ-029 Without BP_STATS_EN, these ports and registers SHALL not exist, and behaviour SHALL otherwise be identical.

Structure
REQ-030 The BTB entry struct (bp_entry_t) and the constants BP_ENTRIES=16 and BP_IDX_W=4 SHALL reside in pipeline_reg_pkg. BP_IDX_W SHALL match the width of the index fields.
REQ-031 The 2-bit saturating counter SHALL be a sub-module, sat_counter2, with inputs inc/dec/cur and output next.

Verification
REQ-032 Reset, then fetch_pc=0x0000_0040 -> pred_taken=0, pred_target=0x0000_0044, pred_index=0.
REQ-033 Update with upd_pc=0x40, taken=1, target=0x100, predict=0 -> mispredict=1, recover_pc=0x100; next cycle, fetch 0x40 -> pred_taken=1, pred_target=0x100.
REQ-034 Hold the same entry and apply two not-taken updates -> ctr goes 2→1→0; fetch 0x40 -> pred_taken=0; a third not-taken update keeps ctr=0.
REQ-035 Four taken updates -> ctr saturates at 3; one not-taken update -> pred_taken still 1.
REQ-036 Alias test: after the REQ-033 setup, fetch 0x80 (same index, different tag) -> pred_taken=0; then a not-taken update at 0x80 -> the entry for 0x40 is unchanged.
REQ-037 Same-cycle update and lookup of index 0 -> lookup returns pre-update values; with BP_STATS_EN, after 5 updates including 2 mispredicts -> stat_branches=5, stat_mispredicts=2.
